// File: rtl/p405s_icu_vb_ctl.sv
// Instruction-cache valid-bit controller: two 32-entry valid vectors (one per way),
// single-bit update and two-cycle flash-invalidate, with a write-forwarded lookup port.
module p405s_icu_vb_ctl (
  input  logic        CB,
  input  logic        resetCore,
  input  logic        vbReq,
  input  logic        vbReqBit,
  input  logic        vbReqWay,
  input  logic [4:8]  vbReqIndex,
  input  logic        vbFlashReq,
  output logic        vbAck,
  output logic        vbBusy,
  output logic [0:31] feedbackVb,
  output logic        newVbBit,
  output logic [4:8]  vbWrIndex,
  output logic        wrFlash,
  input  logic [0:31] newVb,
  input  logic [4:8]  lkupIndex,
  output logic [0:1]  lkupVb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FLASH0 = 2'd2,
    FLASH1 = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // Control outputs are registered from the next-state decode so they are glitch-free.
  logic        ack_r,   ack_nxt_s;
  logic        busy_r,  busy_nxt_s;
  logic        bit_r,   bit_nxt_s;
  logic        flash_r, flash_nxt_s;
  logic        sel_r,   sel_nxt_s;
  logic [4:0]  idx_r,   idx_nxt_s;

  logic [0:31] arr0_r, arr1_r;
  logic [0:31] arr0_nxt_s, arr1_nxt_s;
  logic        load0_s, load1_s;
  logic [0:1]  lkup_r;

  function automatic logic [0:1] lookup_bits(input logic [0:31] a0,
                                             input logic [0:31] a1,
                                             input logic [4:0]  idx);
    lookup_bits = {a0[idx], a1[idx]};
  endfunction

  // State register.
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; flash wins over a simultaneous update request.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    busy_nxt_s  = 1'b0;
    bit_nxt_s   = 1'b0;
    flash_nxt_s = 1'b0;
    sel_nxt_s   = 1'b0;
    idx_nxt_s   = 5'd0;
    case (state_r)
      IDLE: begin
        if (vbFlashReq) begin
          state_nxt_s = FLASH0;
          busy_nxt_s  = 1'b1;
          flash_nxt_s = 1'b1;
        end else if (vbReq) begin
          state_nxt_s = WRITE;
          busy_nxt_s  = 1'b1;
          ack_nxt_s   = 1'b1;
          bit_nxt_s   = vbReqBit;
          sel_nxt_s   = vbReqWay;
          idx_nxt_s   = vbReqIndex;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
      end
      FLASH0: begin
        state_nxt_s = FLASH1;
        busy_nxt_s  = 1'b1;
        flash_nxt_s = 1'b1;
        sel_nxt_s   = 1'b1;
        ack_nxt_s   = 1'b1;
      end
      FLASH1: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Registered control outputs; sel_r doubles as the latched target way.
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      bit_r   <= 1'b0;
      flash_r <= 1'b0;
      sel_r   <= 1'b0;
      idx_r   <= 5'd0;
    end else begin
      ack_r   <= ack_nxt_s;
      busy_r  <= busy_nxt_s;
      bit_r   <= bit_nxt_s;
      flash_r <= flash_nxt_s;
      sel_r   <= sel_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Which way absorbs the generator result this cycle.
  always_comb begin
    load0_s = 1'b0;
    load1_s = 1'b0;
    case (state_r)
      WRITE: begin
        if (sel_r) begin
          load1_s = 1'b1;
        end else begin
          load0_s = 1'b1;
        end
      end
      FLASH0: load0_s = 1'b1;
      FLASH1: load1_s = 1'b1;
      IDLE:   load0_s = 1'b0;
      default: begin
        load0_s = 1'b0;
        load1_s = 1'b0;
      end
    endcase
  end

  // Post-update array values, shared by the array registers and the lookup forward.
  always_comb begin
    if (load0_s) begin
      arr0_nxt_s = newVb;
    end else begin
      arr0_nxt_s = arr0_r;
    end
    if (load1_s) begin
      arr1_nxt_s = newVb;
    end else begin
      arr1_nxt_s = arr1_r;
    end
  end

  // Valid-bit arrays and the registered lookup result.
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      arr0_r <= 32'h0000_0000;
      arr1_r <= 32'h0000_0000;
      lkup_r <= 2'b00;
    end else begin
      arr0_r <= arr0_nxt_s;
      arr1_r <= arr1_nxt_s;
      lkup_r <= lookup_bits(arr0_nxt_s, arr1_nxt_s, lkupIndex);
    end
  end

  assign feedbackVb = sel_r ? arr1_r : arr0_r;
  assign vbAck      = ack_r;
  assign vbBusy     = busy_r;
  assign newVbBit   = bit_r;
  assign vbWrIndex  = idx_r;
  assign wrFlash    = flash_r;
  assign lkupVb     = lkup_r;

endmodule

// File: tb/tb_p405s_icu_vb_ctl.sv
// Scoreboard bench for p405s_icu_vb_ctl: directed update/flash vectors push expected
// ack-cycle generator controls; a negedge monitor pops and compares on every vbAck.
module tb_p405s_icu_vb_ctl;

  logic        CB = 1'b0;
  logic        resetCore;
  logic        vbReq, vbReqBit, vbReqWay, vbFlashReq;
  logic [4:8]  vbReqIndex;
  logic        vbAck, vbBusy, newVbBit, wrFlash;
  logic [0:31] feedbackVb, newVb, gen;
  logic [4:8]  vbWrIndex, lkupIndex;
  logic [0:1]  lkupVb;

  typedef struct {
    logic [31:0] fb;
    logic [4:0]  idx;
    logic        bt;
    logic        fl;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [0:31] m0, m1;

  always #5 CB = ~CB;

  p405s_icu_vb_ctl dut (
    .CB(CB), .resetCore(resetCore), .vbReq(vbReq), .vbReqBit(vbReqBit),
    .vbReqWay(vbReqWay), .vbReqIndex(vbReqIndex), .vbFlashReq(vbFlashReq),
    .vbAck(vbAck), .vbBusy(vbBusy), .feedbackVb(feedbackVb), .newVbBit(newVbBit),
    .vbWrIndex(vbWrIndex), .wrFlash(wrFlash), .newVb(newVb),
    .lkupIndex(lkupIndex), .lkupVb(lkupVb)
  );

  // Behavioural new-valid-bit generator.
  always_comb begin
    gen = feedbackVb;
    gen[vbWrIndex] = newVbBit;
    if (wrFlash) gen = 32'h0000_0000;
  end
  assign newVb = gen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest expected entry.
  always @(negedge CB) begin
    if (vbAck === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_fields", {25'd0, feedbackVb, vbWrIndex, newVbBit, wrFlash},
            {25'd0, e.fb, e.idx, e.bt, e.fl});
      end
    end
  end

  task automatic do_update(input logic b, input logic w, input logic [4:0] idx);
    exp_t       e;
    logic [1:0] pre, post;
    logic [4:0] lk;
    int         n;
    lk    = lkupIndex;
    e.fb  = w ? m1 : m0;
    e.idx = idx;
    e.bt  = b;
    e.fl  = 1'b0;
    sb_q.push_back(e);
    pre = {m0[lk], m1[lk]};
    if (w) m1[idx] = b; else m0[idx] = b;
    post = {m0[lk], m1[lk]};
    vbReqBit = b; vbReqWay = w; vbReqIndex = idx; vbReq = 1'b1;
    n = 0;
    do begin
      @(posedge CB); #1;
      n++;
    end while (vbAck !== 1'b1 && n < 8);
    if (vbAck !== 1'b1) begin
      chk("ack_timeout", 64'd0, 64'd1);
    end else begin
      chk("update_latency", 64'(n), 64'd1);
      chk("lkup_pre", {62'd0, lkupVb}, {62'd0, pre});
    end
    vbReq = 1'b0;
    @(posedge CB); #1;
    chk("lkup_post", {62'd0, lkupVb}, {62'd0, post});
  endtask

  task automatic check_arrays(input string name, input logic [0:31] e0, input logic [0:31] e1);
    logic [0:31] r0, r1;
    for (int i = 0; i < 32; i++) begin
      lkupIndex = i[4:0];
      @(posedge CB); #1;
      r0[i] = lkupVb[0];
      r1[i] = lkupVb[1];
    end
    chk(name, {r0, r1}, {e0, e1});
  endtask

  initial begin
    logic [0:31] a0_save, a1_save;
    logic [4:0]  k;
    logic [4:0]  chain_idx [3];
    logic [4:0]  busy_v, ack_v;
    exp_t        e;

    resetCore = 1'b1; vbReq = 1'b0; vbReqBit = 1'b0; vbReqWay = 1'b0;
    vbReqIndex = 5'd0; vbFlashReq = 1'b0; lkupIndex = 5'd0;
    m0 = 32'h0; m1 = 32'h0;
    repeat (3) @(posedge CB);
    @(negedge CB);
    chk("reset_outputs", {25'd0, vbAck, vbBusy, lkupVb, newVbBit, vbWrIndex, wrFlash, feedbackVb},
        64'd0);
    @(posedge CB); #1;

    // First request issued together with reset release.
    resetCore = 1'b0;
    lkupIndex = 5'd5;
    do_update(1'b1, 1'b1, 5'd5);
    chk("lkup_idx5", {62'd0, lkupVb}, 64'd1);
    check_arrays("arrays_after_way1_idx5", 32'h0000_0000, 32'h0400_0000);

    // Boundary indices in way 0, then invalidate index 0; rewrite of a set bit.
    lkupIndex = 5'd0;
    do_update(1'b1, 1'b0, 5'd0);
    do_update(1'b1, 1'b0, 5'd31);
    do_update(1'b0, 1'b0, 5'd0);
    check_arrays("arrays_idx0_idx31", 32'h0000_0001, 32'h0400_0000);
    do_update(1'b1, 1'b0, 5'd31);
    check_arrays("arrays_rewrite_same", 32'h0000_0001, 32'h0400_0000);

    // Lookup of index 7 held across its own write.
    lkupIndex = 5'd7;
    @(posedge CB); #1;
    chk("lkup7_before", {62'd0, lkupVb}, 64'd0);
    do_update(1'b1, 1'b0, 5'd7);
    chk("lkup7_after", {62'd0, lkupVb}, 64'd2);

    // Flash and update requested together: flash first, update next.
    a0_save = m0;
    e.fb = m1; e.idx = 5'd0; e.bt = 1'b0; e.fl = 1'b1;
    sb_q.push_back(e);
    m0 = 32'h0; m1 = 32'h0;
    e.fb = 32'h0; e.idx = 5'd3; e.bt = 1'b1; e.fl = 1'b0;
    sb_q.push_back(e);
    m1[3] = 1'b1;
    vbFlashReq = 1'b1; vbReq = 1'b1; vbReqBit = 1'b1; vbReqWay = 1'b1; vbReqIndex = 5'd3;
    @(posedge CB); #1;
    chk("flash0_ctl", {61'd0, wrFlash, vbAck, vbBusy}, 64'b101);
    chk("flash0_fb", {32'd0, feedbackVb}, {32'd0, a0_save});
    @(posedge CB); #1;
    chk("flash1_ctl", {61'd0, wrFlash, vbAck, vbBusy}, 64'b111);
    vbFlashReq = 1'b0;
    @(posedge CB); #1;
    chk("post_flash_idle", {61'd0, wrFlash, vbAck, vbBusy}, 64'b000);
    @(posedge CB); #1;
    chk("queued_req_ack", {63'd0, vbAck}, 64'd1);
    vbReq = 1'b0;
    @(posedge CB); #1;
    check_arrays("arrays_after_flash", 32'h0000_0000, 32'h1000_0000);

    // Request held continuously for three indices.
    chain_idx[0] = 5'd10; chain_idx[1] = 5'd20; chain_idx[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      e.fb = m0; e.idx = chain_idx[i]; e.bt = 1'b1; e.fl = 1'b0;
      sb_q.push_back(e);
      m0[chain_idx[i]] = 1'b1;
    end
    k = 5'd0;
    vbReq = 1'b1; vbReqBit = 1'b1; vbReqWay = 1'b0; vbReqIndex = chain_idx[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge CB); #1;
      busy_v[4-c] = vbBusy;
      ack_v[4-c]  = vbAck;
      if (vbAck === 1'b1) begin
        k++;
        if (k < 5'd3) vbReqIndex = chain_idx[k];
        else vbReq = 1'b0;
      end
    end
    vbReq = 1'b0;
    chk("chain_busy", {59'd0, busy_v}, 64'b10101);
    chk("chain_ack", {59'd0, ack_v}, 64'b10101);
    @(posedge CB); #1;
    check_arrays("arrays_after_chain", 32'h0020_0801, 32'h1000_0000);

    // Reset in the middle of a flash.
    a1_save = m1;
    chk("pre_abort_way1_nonzero", {63'd0, (a1_save != 32'h0)}, 64'd1);
    vbFlashReq = 1'b1;
    @(posedge CB); #1;
    chk("abort_in_flash0", {63'd0, wrFlash}, 64'd1);
    resetCore = 1'b1;
    #1;
    chk("abort_outputs", {25'd0, vbAck, vbBusy, lkupVb, newVbBit, vbWrIndex, wrFlash, feedbackVb},
        64'd0);
    vbFlashReq = 1'b0;
    @(posedge CB);
    @(posedge CB); #1;
    resetCore = 1'b0;
    m0 = 32'h0; m1 = 32'h0;
    check_arrays("arrays_after_abort", 32'h0000_0000, 32'h0000_0000);
    do_update(1'b1, 1'b1, 5'd31);
    check_arrays("arrays_final", 32'h0000_0000, 32'h0000_0001);

    repeat (3) @(posedge CB);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p405s_icu_vb_ctl.md
P405S_ICU_VB_CTL -- requirements
Module: p405s_icu_vb_ctl

Interface
REQ-001 CB  in  1  core clock; all state updates on rising edge.
REQ-002 resetCore  in  1  asynchronous, active-high reset.
REQ-003 vbReq  in  1  line valid-bit update request; held high until vbAck.
REQ-004 vbReqBit  in  1  value to write (1 validate after fill, 0 invalidate line).
REQ-005 vbReqWay  in  1  target way (0 or 1).
REQ-006 vbReqIndex[4:8]  in  5  target congruence class.
REQ-007 vbFlashReq  in  1  flash-invalidate-all request; held high until vbAck.
REQ-008 vbAck  out  1  single-cycle pulse, request retired in this cycle.
REQ-009 vbBusy  out  1  high while an update or flash is in progress.
REQ-010 feedbackVb[0:31]  out  32  current 32-bit valid vector of the way being written, to the new-valid-bit generator.
REQ-011 newVbBit  out  1  bit value for the generator.
REQ-012 vbWrIndex[4:8]  out  5  bit position for the generator.
REQ-013 wrFlash  out  1  generator flash control; generator returns all zeros when high.
REQ-014 newVb[0:31]  in  32  merged vector returned combinationally by the generator.
REQ-015 lkupIndex[4:8]  in  5  lookup congruence class.
REQ-016 lkupVb[0:1]  out  2  registered valid bits {way0, way1} at the lookup index.

Function
REQ-017 Storage SHALL be two 32-bit registers, vbArr0 and vbArr1, one per way, bit n = class n.
REQ-018 FSM states SHALL be IDLE, WRITE, FLASH0 and FLASH1.
REQ-019 In IDLE with vbFlashReq=1, the block SHALL go to FLASH0, regardless of vbReq (flash has priority).
REQ-020 In IDLE with vbReq=1 and vbFlashReq=0, the block SHALL latch bit, way and index and go to WRITE.
REQ-021 WRITE SHALL last one cycle.
  - Drives feedbackVb = vbArr[latched way], vbWrIndex = latched index, newVbBit = latched bit, wrFlash = 0.
  - Loads newVb into vbArr[latched way] at the cycle end.
  - Pulses vbAck.
  - Returns to IDLE.
REQ-022 FLASH0 SHALL drive wrFlash=1 and feedbackVb=vbArr0, load newVb into vbArr0, and go to FLASH1.
REQ-023 FLASH1 SHALL do the same for vbArr1, pulse vbAck, and return to IDLE.
REQ-024 Latency SHALL be: update ack 1 cycle after acceptance; flash ack 2 cycles after acceptance.
REQ-025 vbBusy SHALL be 1 in WRITE, FLASH0 and FLASH1, and 0 in IDLE.
REQ-026 Requests seen while vbBusy=1 SHALL be ignored; requesters hold them.
REQ-027 The block SHALL accept a request in the same IDLE cycle that vbReq or vbFlashReq first rises.
REQ-028 Back-to-back operation: a request still held in the first IDLE cycle after an ack SHALL be accepted then.
  - Max throughput is one update per 2 cycles.
REQ-029 In IDLE, outputs SHALL be feedbackVb = vbArr0, newVbBit = 0, vbWrIndex = 0, wrFlash = 0.
REQ-030 lkupVb SHALL register {vbArr0[lkupIndex], vbArr1[lkupIndex]} computed from post-update array values (write-forwarded).
  - A lookup of a class written in cycle N therefore shows the new value in cycle N+1.
REQ-031 Writing an already-matching value SHALL leave the array unchanged and still ack.
REQ-032 Index 31 and index 0 SHALL behave identically to other indices; no wrap or shift.

Reset
REQ-033 While resetCore=1, asynchronously:
  - vbArr0 = vbArr1 = 0.
  - State = IDLE.
  - Outputs vbAck, vbBusy, lkupVb, newVbBit, vbWrIndex, wrFlash = 0.
REQ-034 Reset during WRITE or FLASH SHALL abort the operation; no vbAck is issued.
REQ-035 The first request SHALL be accepted in the first clock edge with resetCore=0.

Verification
REQ-036 After reset: vbReq, bit 1, way 1, index 5 -> next cycle feedbackVb=0, vbWrIndex=5, vbAck=1; then vbArr1=32'h04000000 and lkupIndex=5 gives lkupVb=2'b01.
REQ-037 Validate index 0 and 31 in way 0, then invalidate index 0 -> vbArr0=32'h00000001, with one vbAck per request.
REQ-038 vbFlashReq and vbReq both high in IDLE -> flash taken:
  - FLASH0 then FLASH1 with wrFlash=1.
  - Both arrays become 0.
  - vbAck pulses only in FLASH1.
  - vbReq is accepted next.
REQ-039 vbReq held continuously for 3 different indices -> acks in cycles 2, 4, 6; vbBusy toggles 1,0,1,0,1; all three bits set.
REQ-040 resetCore asserted mid-FLASH0 with arrays non-zero -> immediate zero arrays, IDLE, no vbAck.
REQ-041 lkupIndex=7 held while index 7 way 0 is validated -> lkupVb changes 2'b00 to 2'b10 in the cycle after WRITE.
